// File: rtl/dice_pkg.sv
// Shared types and constants for the electronic-dice capture datapath:
// debounce FSM state encoding, seven-segment face patterns and pip patterns.
package dice_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_CNT = 2'd1,
      HELD      = 2'd2,
      REL_CNT   = 2'd3
   } db_state_t;

   // Active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_FACE1 = 7'h79;
   localparam logic [6:0] SEG_FACE2 = 7'h24;
   localparam logic [6:0] SEG_FACE3 = 7'h30;
   localparam logic [6:0] SEG_FACE4 = 7'h19;
   localparam logic [6:0] SEG_FACE5 = 7'h12;
   localparam logic [6:0] SEG_FACE6 = 7'h02;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-high pip LEDs: [0]TL [1]TR [2]ML [3]C [4]MR [5]BL [6]BR
   localparam logic [6:0] PIP_FACE1 = 7'h08;
   localparam logic [6:0] PIP_FACE2 = 7'h41;
   localparam logic [6:0] PIP_FACE3 = 7'h49;
   localparam logic [6:0] PIP_FACE4 = 7'h63;
   localparam logic [6:0] PIP_FACE5 = 7'h6B;
   localparam logic [6:0] PIP_FACE6 = 7'h77;
   localparam logic [6:0] PIP_NONE  = 7'h00;

   function automatic logic [6:0] seg_decode(input logic [2:0] f);
      case (f)
         3'd1:    return SEG_FACE1;
         3'd2:    return SEG_FACE2;
         3'd3:    return SEG_FACE3;
         3'd4:    return SEG_FACE4;
         3'd5:    return SEG_FACE5;
         3'd6:    return SEG_FACE6;
         default: return SEG_BLANK;
      endcase
   endfunction

   function automatic logic [6:0] pip_decode(input logic [2:0] f);
      case (f)
         3'd1:    return PIP_FACE1;
         3'd2:    return PIP_FACE2;
         3'd3:    return PIP_FACE3;
         3'd4:    return PIP_FACE4;
         3'd5:    return PIP_FACE5;
         3'd6:    return PIP_FACE6;
         default: return PIP_NONE;
      endcase
   endfunction

endpackage

// File: rtl/dice_roll_capture_debounce.sv
// Push-button conditioning: 2-flop synchronizer followed by a press/release
// debounce FSM sharing one stability counter. Emits a single-cycle press
// strobe, combinationally, in the cycle whose closing edge is the capture edge.
module btn_debounce
   import dice_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
)
(
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_p0;
   logic             btn_s;
   db_state_t        state;
   db_state_t        state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   // Bring the asynchronous button into the clock domain
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= 1'b0;
         btn_s   <= 1'b0;
      end else begin
         sync_p0 <= btn;
         btn_s   <= sync_p0;
      end
   end

   // FSM state and shared stability counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic; press fires only on the PRESS_CNT -> HELD transition
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      press      = 1'b0;
      case (state)
         IDLE: begin
            if (btn_s) begin
               state_next = PRESS_CNT;
               cnt_next   = '0;
            end
         end
         PRESS_CNT: begin
            if (!btn_s) begin
               state_next = IDLE;
            end else if (cnt == CNT_LAST) begin
               press      = 1'b1;
               state_next = HELD;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         HELD: begin
            if (!btn_s) begin
               state_next = REL_CNT;
               cnt_next   = '0;
            end
         end
         REL_CNT: begin
            if (btn_s) begin
               state_next = HELD;
            end else if (cnt == CNT_LAST) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: rtl/dice_roll_capture.sv
// Electronic-dice capture: on each debounced press, latch the modulo-6
// counter as a die face, strobe roll_valid, keep a saturating tally, flag
// illegal counter values, and drive the face on a seven-segment display.
// Optional macro DICE_PIPS_EN adds the pips LED output.
module dice_roll_capture
   import dice_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] count,
   input  logic       btn,
   output logic       roll_valid,
   output logic [2:0] face,
   output logic [6:0] seg,
   output logic [7:0] roll_count,
   output logic       err
`ifdef DICE_PIPS_EN
   ,
   output logic [6:0] pips
`endif
);

   logic press;
   logic legal;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .btn   (btn),
      .press (press)
   );

   assign legal = (count <= 3'd5);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Capture the face on a press; illegal counter values only raise err
   always_ff @(posedge clk) begin
      if (reset) begin
         face       <= 3'd0;
         roll_valid <= 1'b0;
         roll_count <= 8'd0;
         err        <= 1'b0;
      end else begin
         roll_valid <= 1'b0;
         if (press) begin
            if (legal) begin
               face       <= count + 3'd1;
               roll_valid <= 1'b1;
               roll_count <= sat_inc(roll_count);
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

   assign seg = seg_decode(face);

`ifdef DICE_PIPS_EN
   assign pips = pip_decode(face);
`endif

endmodule

// File: doc/dice_roll_capture.md
# dice_roll_capture

Downstream consumer of the free-running synchronous modulo-6 counter (count values 0..5). On each debounced press of a raw push-button it captures the counter's current value as a die face (1..6), pulses a valid strobe, keeps a saturating roll tally, and drives an active-low seven-segment display of the held face. Together with the counter it forms the electronic-dice datapath; the counter's `en` is tied high so its value at press time is effectively random.

## Interface
- `DEBOUNCE_CYCLES`, default 4: stable cycles required on press and on release; legal range 1..2^20; counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

- `clk`  in  1  single system clock, rising-edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- `count`  in  3  modulo-6 counter value {q2,q1,q0}; legal values 0..5.
- `btn`  in  1  raw, asynchronous, bouncing push-button, active-high.
- `roll_valid`  out  1  one-cycle pulse when a new face has been captured.
- `face`  out  3  held face, 1..6; 0 means no roll since reset.
- `seg`  out  7  active-low segments {g,f,e,d,c,b,a} decoded from `face`.
- `roll_count`  out  8  number of accepted rolls, saturates at 255.
- `err`  out  1  sticky: an illegal `count` (6 or 7) was sampled at capture.
- `pips`  out  7  only with `DICE_PIPS_EN`; see Configuration.

## Operation
- `btn` passes through a 2-flop synchronizer, producing `btn_s`.
- Debounce FSM, states IDLE, PRESS_CNT, HELD, REL_CNT; shared counter `cnt`:
  - IDLE: `btn_s`=1 -> PRESS_CNT, `cnt`<=0.
  - PRESS_CNT: `btn_s`=0 -> IDLE. `btn_s`=1 and `cnt`==DEBOUNCE_CYCLES-1 -> capture, go to HELD. Otherwise `cnt`++.
  - HELD: `btn_s`=0 -> REL_CNT, `cnt`<=0.
  - REL_CNT: `btn_s`=1 -> HELD. `btn_s`=0 and `cnt`==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise `cnt`++.
- Capture with `count` 0..5: `face`<=`count`+1, `roll_valid`<=1, and `roll_count`<=`roll_count`+1 unless it is already 255.
- Capture with `count` 6/7: `face`, `roll_count` and `roll_valid` do not change; `err`<=1. `err` clears only on `reset`.
- Exactly one capture per press; holding `btn` never repeats.
- `seg` decode of `face` (active-low): 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02. For 0 and 7 the output is 7'h7F (blank).

## Timing
- Reset values: synchronizer 0, FSM IDLE, `cnt` 0, `face` 0, `seg` 7'h7F, `roll_valid` 0, `roll_count` 0, `err` 0, `pips` 0.
- Edge 0 is the first rising edge that samples `btn`=1, with `btn` stable from then on:
  - `btn_s` goes high after edge 1.
  - The FSM enters PRESS_CNT at edge 2.
  - The capture edge is DEBOUNCE_CYCLES+2.
- On the capture edge, `face` and `roll_count` update. `roll_valid` is high for exactly the following cycle.
- The `count` value sampled is the one present immediately before the capture edge.
- `seg` and `pips` are combinational from the `face` register and have no added latency.
- Any glitch shorter than DEBOUNCE_CYCLES cycles (after synchronizing) produces no capture.
- Reset mid-press discards all progress. If `btn` is still held when `reset` is released, a full debounce runs again and a capture occurs.
- `reset` asserted on the capture edge wins: no capture happens.

## Configuration
- `DICE_PIPS_EN` defined: adds the `pips` output, active-high LED bits [0]TL [1]TR [2]ML [3]C [4]MR [5]BL [6]BR.
  - Encoding by face: 1=7'h08, 2=7'h41, 3=7'h49, 4=7'h63, 5=7'h6B, 6=7'h77.
  - Faces 0 and 7 give 7'h00.
- `DICE_PIPS_EN` undefined: the `pips` port and its decode are absent. All other behaviour is identical.

## Structure
- Package `dice_pkg` holds:
  - the debounce FSM state enum;
  - the seven-segment face constants and the blank constant 7'h7F;
  - the pip pattern constants.
- Sub-module `btn_debounce` contains the synchronizer, the FSM and `cnt`, and emits a one-cycle `press` pulse at the capture edge. The top level holds the capture, tally, error and decode logic.

## Test plan
- Clean press, DEBOUNCE_CYCLES=4, `count`=3 constant: `roll_valid` pulses once at edge 6 after `btn` rises; `face`=4, `seg`=7'h19, `roll_count`=1.
- Bounce: `btn` toggles 1/0 every 2 cycles for 20 cycles, then stays high with `count`=0: only one capture, after the stable period, with `face`=1.
- Hold `btn` for 100 cycles, release, press again with `count`=5: exactly two `roll_valid` pulses; final `face`=6, `seg`=7'h02.
- Force `count`=7 at capture: `err`=1, `face`/`roll_count` unchanged, no `roll_valid`. A following legal press still captures, and `err` stays 1.
- 260 legal presses: `roll_count` reaches 255 and holds there.
- Assert `reset` during PRESS_CNT with `btn` held: all outputs return to reset values, blank `seg`. After reset release a capture occurs DEBOUNCE_CYCLES+2 edges later.
